// File: rtl/uart_fifo_bridge_pkg.sv
// Shared definitions for the uart bridge: register map, CTRL/STATUS bit positions, TX FSM states.
package uart_fifo_bridge_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int unsigned CTRL_EN        = 0;
    localparam int unsigned CTRL_RX_IRQ_EN = 1;
    localparam int unsigned CTRL_TX_IRQ_EN = 2;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_t;

    // STATUS layout: {0, tx_drop, rx_overrun, tx_busy_any, tx_full, tx_empty, rx_full, rx_empty}
    function automatic logic [7:0] pack_status(
        input logic tx_drop, input logic rx_overrun, input logic tx_busy_any,
        input logic tx_full, input logic tx_empty, input logic rx_full, input logic rx_empty);
        return {1'b0, tx_drop, rx_overrun, tx_busy_any, tx_full, tx_empty, rx_full, rx_empty};
    endfunction

endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; extra pointer MSB separates full from empty.
module sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0]    mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign dout = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// CPU register front end for the uart core: DATA/STATUS/CTRL registers, TX and RX FIFOs, TX handshake FSM.
module uart_fifo_bridge
    import uart_fifo_bridge_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] bus_addr,
    input  logic       bus_wr,
    input  logic       bus_rd,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       irq,
    output logic       uart_en,
    output logic       uart_we,
    output logic [7:0] uart_data_in,
    input  logic       uart_tx_busy,
    input  logic       uart_rx_done,
    input  logic [7:0] uart_data_out
);

    tx_state_t  tx_state;
    tx_state_t  tx_next;
    logic [2:0] ctrl;
    logic       tx_drop;
    logic       rx_overrun;
    logic       tx_push;
    logic       tx_pop;
    logic       tx_full;
    logic       tx_empty;
    logic [7:0] tx_head;
    logic       rx_pop;
    logic       rx_full;
    logic       rx_empty;
    logic [7:0] rx_head;
    logic       tx_busy_any;
    logic       status_rd;
    logic       tx_drop_set;
    logic       rx_overrun_set;

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus_wdata),
        .dout(tx_head), .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(uart_rx_done), .pop(rx_pop), .din(uart_data_out),
        .dout(rx_head), .full(rx_full), .empty(rx_empty)
    );

    assign uart_en     = ctrl[CTRL_EN];
    assign uart_we     = (tx_state == TX_REQ);
    assign tx_busy_any = ~tx_empty | (tx_state != TX_IDLE);
    assign tx_push     = bus_wr & (bus_addr == ADDR_DATA);
    assign rx_pop      = bus_rd & (bus_addr == ADDR_DATA) & ~rx_empty;
    assign status_rd   = bus_rd & (bus_addr == ADDR_STATUS);

    // A write or capture is only lost if the FIFO stays full after the same-cycle pop.
    assign tx_drop_set    = tx_push & tx_full & ~tx_pop;
    assign rx_overrun_set = uart_rx_done & rx_full & ~rx_pop;

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (ctrl[CTRL_EN] & ~tx_empty & ~uart_tx_busy) begin
                    tx_pop  = 1'b1;
                    tx_next = TX_REQ;
                end
            end
            TX_REQ: begin
                if (~ctrl[CTRL_EN])   tx_next = TX_IDLE;
                else if (uart_tx_busy) tx_next = TX_WAIT;
            end
            TX_WAIT: begin
                if (~uart_tx_busy) tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state     <= TX_IDLE;
            uart_data_in <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_pop) uart_data_in <= tx_head;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl       <= '0;
            tx_drop    <= 1'b0;
            rx_overrun <= 1'b0;
            bus_rdata  <= '0;
            irq        <= 1'b0;
        end else begin
            if (bus_wr && bus_addr == ADDR_CTRL) ctrl <= bus_wdata[2:0];
            tx_drop    <= tx_drop_set    | (tx_drop    & ~status_rd);
            rx_overrun <= rx_overrun_set | (rx_overrun & ~status_rd);
            if (bus_rd) begin
                case (bus_addr)
                    ADDR_DATA:   bus_rdata <= rx_empty ? 8'h00 : rx_head;
                    ADDR_STATUS: bus_rdata <= pack_status(tx_drop, rx_overrun, tx_busy_any,
                                                          tx_full, tx_empty, rx_full, rx_empty);
                    ADDR_CTRL:   bus_rdata <= {5'b0, ctrl};
                    default:     bus_rdata <= '0;
                endcase
            end
            irq <= (ctrl[CTRL_RX_IRQ_EN] & ~rx_empty) |
                   (ctrl[CTRL_TX_IRQ_EN] & tx_empty & (tx_state == TX_IDLE));
        end
    end

endmodule
